mem_rd_ctrl: RTL

- Sequences every load through the dcache read-data path and the IO read path.
- Latches a load request (address, size) and classifies it as IO, single-line cache, or line-crossing cache.
- Drives dcache read enables and addresses, plus `addr_offset` / `access2_reg` for the read-data generator.
- Signals `mem_rd_ready` in the exact cycle the assembled data is valid; sits between the load/operand-read stage and the dcache/IO interface.

---
 rtl/mem_rd_ctrl_pkg.sv | 7 +
 rtl/mem_rd_timeout_cnt.sv | 15 +
 rtl/mem_rd_ctrl.sv | 71 +++++++
 3 files changed

// File: rtl/mem_rd_ctrl_pkg.sv
// mem_rd_ctrl_pkg: shared FSM state encoding and line geometry for the load read controller
package mem_rd_ctrl_pkg;
  typedef enum logic [1:0] {IDLE = 2'd0, DC1 = 2'd1, DC2 = 2'd2, IO_WAIT = 2'd3} state_e;
  localparam int LINE_BYTES = 16;
  localparam int LINE_OFF_W = 4;
  localparam logic [15:0] IO_PAGE_DEF = 16'hFFFF;
endpackage

// File: rtl/mem_rd_timeout_cnt.sv
// mem_rd_timeout_cnt: 8-bit counter (clk, rst, clr, en in; limit in; tc out when count equals limit)
module mem_rd_timeout_cnt (
  input  logic       clk,
  input  logic       rst,
  input  logic       clr,
  input  logic       en,
  input  logic [7:0] limit,
  output logic       tc
);
  logic [7:0] cnt_q;
  always_ff @(posedge clk)
    if (rst || clr) cnt_q <= '0;
    else if (en) cnt_q <= cnt_q + 8'd1;
  assign tc = cnt_q == limit;
endmodule

// File: rtl/mem_rd_ctrl.sv
// mem_rd_ctrl: load sequencer (rd_req/rd_addr/rd_size/flush in; dc_rd_en/dc_rd_addr/addr_offset/access2_reg to dcache, io_req/io_addr/io_ack to IO, mem_rd_ready/io_err/rd_busy out)
module mem_rd_ctrl
  import mem_rd_ctrl_pkg::*;
#(
  parameter int          ADDR_W     = 32,
  parameter logic [15:0] IO_PAGE    = IO_PAGE_DEF,
  parameter int          IO_TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rd_req,
  input  logic [ADDR_W-1:0] rd_addr,
  input  logic [3:0]        rd_size,
  input  logic              flush,
  output logic              rd_busy,
  output logic              dc_rd_en,
  output logic [ADDR_W-1:0] dc_rd_addr,
  input  logic              dc_read_hit,
  output logic [3:0]        addr_offset,
  output logic              access2_reg,
  output logic              io_req,
  output logic [ADDR_W-1:0] io_addr,
  input  logic              io_ack,
  output logic              io_err,
  output logic              mem_rd_ready
);
  state_e state_q, state_d;
  logic [ADDR_W-1:0] addr_q;
  logic cross_q, io_d, cross_d, tc;
  assign io_d    = rd_addr[ADDR_W-1 -: 16] == IO_PAGE;
  assign cross_d = ({1'b0, rd_addr[LINE_OFF_W-1:0]} + {1'b0, rd_size}) > 5'(LINE_BYTES);
  always_comb
    state_d = (state_q == IDLE)    ? (rd_req ? (io_d ? IO_WAIT : DC1) : IDLE)
            : (state_q == IO_WAIT) ? ((io_ack || tc) ? IDLE : IO_WAIT)
            : flush                ? IDLE
            : !dc_read_hit         ? state_q
            : (state_q == DC1 && cross_q) ? DC2 : IDLE;
  always_ff @(posedge clk)
    if (rst) begin
      state_q <= IDLE;
      addr_q  <= '0;
      cross_q <= 1'b0;
    end else begin
      state_q <= state_d;
      if (state_q == IDLE && rd_req) begin
        addr_q  <= rd_addr;
        cross_q <= cross_d;
      end
    end
  mem_rd_timeout_cnt u_tmo (
    .clk  (clk),
    .rst  (rst),
    .clr  (state_q != IO_WAIT),
    .en   (state_q == IO_WAIT),
    .limit(8'(IO_TIMEOUT - 1)),
    .tc   (tc)
  );
  assign rd_busy     = state_q != IDLE;
  assign dc_rd_en    = state_q == DC1 || state_q == DC2;
  assign access2_reg = state_q == DC2;
  assign io_req      = state_q == IO_WAIT;
  assign io_addr     = io_req ? addr_q : '0;
  assign addr_offset = rd_busy ? addr_q[LINE_OFF_W-1:0] : 4'h0;
  // second line address wraps naturally in the truncated line-number add
  assign dc_rd_addr  = (state_q == DC1) ? {addr_q[ADDR_W-1:LINE_OFF_W], 4'h0}
                     : (state_q == DC2) ? {addr_q[ADDR_W-1:LINE_OFF_W] + 1'b1, 4'h0} : '0;
  // a hit in DC1 of a crossing load only loads the first half, so it is not ready yet
  assign mem_rd_ready = !rst && ((dc_rd_en && dc_read_hit && !flush && !(state_q == DC1 && cross_q))
                               || (io_req && io_ack));
  assign io_err = !rst && io_req && !io_ack && tc;
endmodule
